// File: rtl/ff_pkg.sv
// Shared encodings for the multi-mode flip-flop bank: update modes and the
// SR-mode policy applied when S and R are both asserted.
package ff_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } mode_e;

  localparam int SR_HOLD  = 0;
  localparam int SR_SET   = 1;
  localparam int SR_RESET = 2;

endpackage

// File: rtl/ff_bank_multimode_if.sv
// Control/data bundle between a driver and the multi-mode flip-flop bank.
interface ff_bank_multimode_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] qn_bar;
  logic [WIDTH-1:0] toggled;
  logic             illegal_flag;
  logic [CNT_W-1:0] change_cnt;

  modport master (
    output en, mode, a, b, clr,
    input  qn, qn_bar, toggled, illegal_flag, change_cnt
  );

  modport slave (
    input  en, mode, a, b, clr,
    output qn, qn_bar, toggled, illegal_flag, change_cnt
  );
endinterface

// File: rtl/t_ff_bank.sv
// Plain bank of T-type flip-flops: each set bit of i_t flips the matching
// stored bit. Knows nothing about the D/T/SR/JK modes above it.
module t_ff_bank #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_t,
  output logic [WIDTH-1:0] o_qn,
  output logic [WIDTH-1:0] o_qn_bar
);

  logic [WIDTH-1:0] r_qn;

  // Storage: reload on reset, otherwise apply the toggle vector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_qn <= RESET_VAL;
    end else begin
      r_qn <= r_qn ^ i_t;
    end
  end

  assign o_qn     = r_qn;
  assign o_qn_bar = ~r_qn;

endmodule

// File: rtl/ff_bank_multimode.sv
// Multi-mode flip-flop bank. Each mode is reduced to a per-bit toggle vector
// that drives a T-type storage bank; also tracks illegal SR requests and a
// saturating count of cycles in which the stored value changed.
module ff_bank_multimode
  import ff_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
  parameter int               SR_ILLEGAL = 0,
  parameter int unsigned      CNT_W      = 8
) (
  input logic                clk,
  input logic                rst,
  ff_bank_multimode_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] w_qn;
  logic [WIDTH-1:0] w_qn_bar;
  logic [WIDTH-1:0] w_both;
  logic [WIDTH-1:0] w_sr_both_val;
  logic [WIDTH-1:0] w_nx;
  logic [WIDTH-1:0] w_t;
  logic             w_illegal;
  logic             w_change;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_next;

  logic [WIDTH-1:0] r_toggled;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  assign w_both = bus.a & bus.b;

  // Value an SR bit takes when S and R are both high, fixed by SR_ILLEGAL.
  always_comb begin
    w_sr_both_val = w_qn;
    if (SR_ILLEGAL == SR_SET) begin
      w_sr_both_val = {WIDTH{1'b1}};
    end else if (SR_ILLEGAL == SR_RESET) begin
      w_sr_both_val = {WIDTH{1'b0}};
    end else begin
      w_sr_both_val = w_qn;
    end
  end

  // Mode decoder: per-bit next value. Bits with a=b=0 hold in SR/JK.
  always_comb begin
    w_nx = w_qn;
    case (bus.mode)
      MODE_D:  w_nx = bus.a;
      MODE_T:  w_nx = w_qn ^ bus.a;
      MODE_SR: w_nx = (bus.a & ~bus.b) | (w_qn & ~bus.a & ~bus.b)
                    | (w_both & w_sr_both_val);
      MODE_JK: w_nx = (bus.a & ~bus.b) | (w_qn & ~bus.a & ~bus.b)
                    | (w_both & ~w_qn);
      default: w_nx = w_qn;
    endcase
  end

  // Toggle vector and the per-cycle events it produces.
  always_comb begin
    w_t       = {WIDTH{1'b0}};
    w_illegal = 1'b0;
    if (bus.en) begin
      w_t       = w_nx ^ w_qn;
      w_illegal = (bus.mode == MODE_SR) && (|w_both);
    end else begin
      w_t       = {WIDTH{1'b0}};
      w_illegal = 1'b0;
    end
    w_change = |w_t;
  end

  // Counter next value: clr zeroes first, a change event then adds one
  // unless already saturated.
  always_comb begin
    w_cnt_base = bus.clr ? {CNT_W{1'b0}} : r_cnt;
    w_cnt_next = w_cnt_base;
    if (w_change && (w_cnt_base != CNT_MAX)) begin
      w_cnt_next = w_cnt_base + CNT_ONE;
    end else begin
      w_cnt_next = w_cnt_base;
    end
  end

  // Status registers: last toggle vector, sticky illegal flag, change count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_toggled <= {WIDTH{1'b0}};
      r_illegal <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
    end else begin
      r_toggled <= w_t;
      r_illegal <= (r_illegal & ~bus.clr) | w_illegal;
      r_cnt     <= w_cnt_next;
    end
  end

  t_ff_bank #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .i_t     (w_t),
    .o_qn    (w_qn),
    .o_qn_bar(w_qn_bar)
  );

  assign bus.qn           = w_qn;
  assign bus.qn_bar       = w_qn_bar;
  assign bus.toggled      = r_toggled;
  assign bus.illegal_flag = r_illegal;
  assign bus.change_cnt   = r_cnt;

endmodule

// File: tb/tb_ff_bank_multimode.sv
// Bench for ff_bank_multimode: three instances with different SR policies,
// reset values and counter widths share one stimulus stream and are
// compared against a per-bit behavioural model after every edge.
module tb_ff_bank_multimode;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ff_bank_multimode_if #(.WIDTH(8), .CNT_W(8)) if0 ();
  ff_bank_multimode_if #(.WIDTH(8), .CNT_W(2)) if1 ();
  ff_bank_multimode_if #(.WIDTH(8), .CNT_W(2)) if2 ();

  ff_bank_multimode #(.WIDTH(8), .RESET_VAL(8'hA5), .SR_ILLEGAL(1), .CNT_W(8))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  ff_bank_multimode #(.WIDTH(8), .RESET_VAL(8'h3C), .SR_ILLEGAL(0), .CNT_W(2))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  ff_bank_multimode #(.WIDTH(8), .RESET_VAL(8'hFF), .SR_ILLEGAL(2), .CNT_W(2))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state, one entry per instance.
  logic [7:0] m_qn  [3];
  logic [7:0] m_tog [3];
  logic       m_flag[3];
  int         m_cnt [3];
  logic [7:0] m_rv  [3] = '{8'hA5, 8'h3C, 8'hFF};
  int         m_pol [3] = '{1, 0, 2};
  int         m_max [3] = '{255, 3, 3};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the spec's rules for instance k.
  function automatic void model_edge(input int k, input logic r, input logic en,
                                     input logic [1:0] mode, input logic [7:0] a,
                                     input logic [7:0] b, input logic clr);
    logic [7:0] nx;
    logic [7:0] t;
    if (!r) begin
      m_qn[k] = m_rv[k]; m_tog[k] = 8'h00; m_flag[k] = 1'b0; m_cnt[k] = 0;
      return;
    end
    nx = m_qn[k];
    for (int i = 0; i < 8; i++) begin
      case (mode)
        2'd0: nx[i] = a[i];
        2'd1: nx[i] = a[i] ? ~m_qn[k][i] : m_qn[k][i];
        2'd2: begin
          if (a[i] && b[i]) nx[i] = (m_pol[k] == 1) ? 1'b1 : (m_pol[k] == 2) ? 1'b0 : m_qn[k][i];
          else if (a[i]) nx[i] = 1'b1;
          else if (b[i]) nx[i] = 1'b0;
        end
        default: begin
          if (a[i] && b[i]) nx[i] = ~m_qn[k][i];
          else if (a[i]) nx[i] = 1'b1;
          else if (b[i]) nx[i] = 1'b0;
        end
      endcase
    end
    t = en ? (nx ^ m_qn[k]) : 8'h00;
    if (clr) begin m_flag[k] = 1'b0; m_cnt[k] = 0; end
    if (en && mode == 2'd2 && (a & b) != 8'h00) m_flag[k] = 1'b1;
    if (t != 8'h00 && m_cnt[k] < m_max[k]) m_cnt[k]++;
    m_qn[k]  = m_qn[k] ^ t;
    m_tog[k] = t;
  endfunction

  task automatic check_inst(input string nm, input int k, input logic [7:0] qn,
                            input logic [7:0] qnb, input logic [7:0] tog,
                            input logic flag, input logic [7:0] cnt);
    check_val({nm, ".qn"}, {24'h0, qn}, {24'h0, m_qn[k]});
    check_val({nm, ".qn_bar"}, {24'h0, qnb}, {24'h0, ~m_qn[k]});
    check_val({nm, ".toggled"}, {24'h0, tog}, {24'h0, m_tog[k]});
    check_val({nm, ".flag"}, {31'h0, flag}, {31'h0, m_flag[k]});
    check_val({nm, ".cnt"}, {24'h0, cnt}, m_cnt[k]);
  endtask

  // Apply one cycle of stimulus to all instances, advance the model, check.
  task automatic step(input logic r, input logic en, input logic [1:0] mode,
                      input logic [7:0] a, input logic [7:0] b, input logic clr);
    @(negedge clk);
    rst = r;
    if0.en = en; if0.mode = mode; if0.a = a; if0.b = b; if0.clr = clr;
    if1.en = en; if1.mode = mode; if1.a = a; if1.b = b; if1.clr = clr;
    if2.en = en; if2.mode = mode; if2.a = a; if2.b = b; if2.clr = clr;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k, r, en, mode, a, b, clr);
    #1;
    check_inst("u0", 0, if0.qn, if0.qn_bar, if0.toggled, if0.illegal_flag, if0.change_cnt);
    check_inst("u1", 1, if1.qn, if1.qn_bar, if1.toggled, if1.illegal_flag, {6'h0, if1.change_cnt});
    check_inst("u2", 2, if2.qn, if2.qn_bar, if2.toggled, if2.illegal_flag, {6'h0, if2.change_cnt});
  endtask

  initial begin
    // Reset for two edges, then release.
    step(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    check_val("rst_qn", {24'h0, if0.qn}, 32'hA5);
    check_val("rst_qn_bar", {24'h0, if0.qn_bar}, 32'h5A);
    check_val("rst_cnt", {24'h0, if0.change_cnt}, 32'h0);

    // D then T.
    step(1'b1, 1'b1, 2'd0, 8'h3C, 8'h00, 1'b0);
    check_val("d_qn", {24'h0, if0.qn}, 32'h3C);
    check_val("d_tog", {24'h0, if0.toggled}, 32'h99);
    check_val("d_cnt", {24'h0, if0.change_cnt}, 32'h1);
    step(1'b1, 1'b1, 2'd1, 8'h0F, 8'h00, 1'b0);
    check_val("t_qn", {24'h0, if0.qn}, 32'h33);
    check_val("t_tog", {24'h0, if0.toggled}, 32'h0F);
    check_val("t_cnt", {24'h0, if0.change_cnt}, 32'h2);

    // SR with one illegal bit; flag must persist across idle cycles.
    step(1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h81, 8'h01, 1'b0);
    check_val("sr_qn", {24'h0, if0.qn}, 32'h81);
    check_val("sr_flag", {31'h0, if0.illegal_flag}, 32'h1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd2, 8'h00, 8'h00, 1'b0);
    check_val("sr_flag_hold", {31'h0, if0.illegal_flag}, 32'h1);

    // JK toggle, then en=0 gating.
    step(1'b1, 1'b1, 2'd0, 8'hF0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'd3, 8'hFF, 8'hFF, 1'b0);
    check_val("jk_qn", {24'h0, if0.qn}, 32'h0F);
    step(1'b1, 1'b0, 2'd3, 8'hFF, 8'hFF, 1'b0);
    check_val("jk_hold_qn", {24'h0, if0.qn}, 32'h0F);
    check_val("jk_hold_tog", {24'h0, if0.toggled}, 32'h00);

    // Saturation on the 2-bit counters, then clr behaviour.
    step(1'b1, 1'b0, 2'd1, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'd1, 8'h01, 8'h00, 1'b0);
    check_val("sat_cnt", {30'h0, if1.change_cnt}, 32'h3);
    step(1'b1, 1'b1, 2'd1, 8'h01, 8'h00, 1'b1);
    check_val("clr_tog_cnt", {30'h0, if1.change_cnt}, 32'h1);
    step(1'b1, 1'b0, 2'd1, 8'h01, 8'h00, 1'b1);
    check_val("clr_idle_cnt", {30'h0, if1.change_cnt}, 32'h0);

    // clr together with an illegal SR request leaves the flag set.
    step(1'b1, 1'b1, 2'd2, 8'h10, 8'h10, 1'b1);
    check_val("clr_ill_flag", {31'h0, if2.illegal_flag}, 32'h1);

    // Reset in the middle of an active D update.
    step(1'b1, 1'b1, 2'd3, 8'h5A, 8'h33, 1'b0);
    step(1'b0, 1'b1, 2'd0, 8'hFF, 8'h00, 1'b0);
    check_val("mid_rst_qn", {24'h0, if0.qn}, 32'hA5);
    check_val("mid_rst_flag", {31'h0, if0.illegal_flag}, 32'h0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(31) != 0), ($urandom_range(3) != 0), 2'($urandom_range(3)),
           8'($urandom), 8'($urandom), ($urandom_range(15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
